mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive D-grants allowed while I is pending before I is forced.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the memory-response watchdog limit (used only with RVM_ARB_TIMEOUT_EN).
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Ports i_req / i_addr  input  1/`ADDR_WIDTH: instruction-fetch request and word address.
REQ-006 Ports i_ack / i_rdata  output  1/`INSTR_WIDTH: one-cycle completion pulse and fetched instruction.
REQ-007 Ports d_req / d_we / d_mode / d_addr / d_wdata  input  1/1/1/`ADDR_WIDTH/`WORD_WIDTH: data request, write enable, access mode, address, write data.
REQ-008 Ports d_ack / d_rdata  output  1/`WORD_WIDTH: one-cycle completion pulse and load data.
REQ-009 Ports mem_req / mem_we / mem_mode / mem_addr / mem_wdata  output  1/1/1/`ADDR_WIDTH/`WORD_WIDTH: unified single-port memory request, all registered.
REQ-010 Ports mem_ready / mem_rdata  input  1/`WORD_WIDTH: memory completion strobe and read data.
REQ-011 Ports i_stall / d_stall  output  1/1: asserted while the matching req is high and its ack has not been given; feeds the hazard unit.
REQ-012 Port err  output  1: sticky timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP.
REQ-014 IDLE: with d_req high, d_req wins unless starve_cnt == STARVE_MAX and i_req high; otherwise i_req wins; winner's request fields SHALL be latched and the FSM SHALL enter BUSY_x.
REQ-015 In BUSY_x, mem_req SHALL be 1 with latched fields stable until mem_ready is sampled 1, then the FSM SHALL enter RESP.
REQ-016 mem_rdata SHALL be registered on the mem_ready cycle; in RESP the winner's ack SHALL pulse exactly one cycle with rdata valid; the FSM then returns to IDLE.
REQ-017 Minimum latency SHALL be 3 cycles from req sampled in IDLE to ack (IDLE, BUSY with mem_ready, RESP).
REQ-018 Requesters SHALL hold req and fields until ack; a deasserted req mid-transaction SHALL NOT abort it.
REQ-019 starve_cnt SHALL increment on each D grant while i_req is high, saturate at STARVE_MAX, and clear on any I grant or when i_req is low at grant time.
REQ-020 i_rdata / d_rdata SHALL hold their last value outside ack cycles; d_rdata SHALL be unchanged by writes.
REQ-021 mem_ready outside BUSY_x SHALL be ignored.

Reset
REQ-022 On rst_n low: FSM = IDLE, starve_cnt = 0, mem_req = mem_we = mem_mode = 0, mem_addr = mem_wdata = 0, i_ack = d_ack = 0, rdata registers = 0, err = 0.
REQ-023 Reset mid-transaction SHALL drop mem_req immediately with no ack issued.

Configuration
REQ-024 With RVM_ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY_x; on reaching TIMEOUT_CYCLES without mem_ready the FSM SHALL enter RESP, ack the winner with rdata = 0, and set err until reset.
REQ-025 Without RVM_ARB_TIMEOUT_EN, BUSY_x SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum arb_state_t and the grant encoding (GNT_I, GNT_D); widths SHALL come from the common defs.
REQ-027 The watchdog SHALL be sub-module arb_wdog (enable, clear, expire), instantiated only under RVM_ARB_TIMEOUT_EN.

Verification
REQ-028 i_req alone, addr 0x100, mem_ready 2 cycles after mem_req -> i_ack after 4 cycles with i_rdata = mem_rdata, d_stall = 0.
REQ-029 i_req and d_req in the same cycle (d_we = 1, addr 0x200, wdata 0xDEADBEEF) -> D served first with mem_we = 1, then I; i_stall high throughout the D access.
REQ-030 d_req held continuously with i_req high, STARVE_MAX = 4 -> grant order D,D,D,D,I,D.
REQ-031 rst_n pulsed low in BUSY_D -> mem_req = 0 asynchronously, no d_ack, FSM = IDLE after release.
REQ-032 With RVM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_ready never asserted -> ack after 8 busy cycles, rdata = 0, err = 1 until reset.
REQ-033 Spurious mem_ready in IDLE -> no ack and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Bus widths come from the common ADDR_WIDTH / INSTR_WIDTH / WORD_WIDTH defines;
// they fall back to 32 bits when no common defs were compiled ahead of this file.
// Optional response watchdog is enabled by defining RVM_ARB_TIMEOUT_EN.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int INSTR_W = `INSTR_WIDTH;
  localparam int WORD_W  = `WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and stall signals around the arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.

interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic               i_ack;
  logic [INSTR_W-1:0] i_rdata;

  logic               d_req;
  logic               d_we;
  logic               d_mode;
  logic [ADDR_W-1:0]  d_addr;
  logic [WORD_W-1:0]  d_wdata;
  logic               d_ack;
  logic [WORD_W-1:0]  d_rdata;

  logic               mem_req;
  logic               mem_we;
  logic               mem_mode;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WORD_W-1:0]  mem_wdata;
  logic               mem_ready;
  logic [WORD_W-1:0]  mem_rdata;

  logic               i_stall;
  logic               d_stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
    output i_stall, d_stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_req, mem_we, mem_mode, mem_addr, mem_wdata,
    input  i_stall, d_stall
  );

endinterface

// File: rtl/arb_wdog.sv
// Memory-response watchdog for the arbiter, only built when RVM_ARB_TIMEOUT_EN
// is defined. Counts enabled cycles and flags expiry on the last allowed one.

`ifdef RVM_ARB_TIMEOUT_EN
module arb_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one single-port memory.
// Data wins ties unless instruction fetch has been starved STARVE_MAX times.
// Define RVM_ARB_TIMEOUT_EN to add a response watchdog that forces a zero
// response and sets the sticky err flag after TIMEOUT_CYCLES busy cycles.

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  if ((STARVE_MAX < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("mem_arbiter: STARVE_MAX and TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t         state_q, state_d;
  arb_gnt_t           gnt_q, gnt_d;
  logic [SW-1:0]      starveCnt_q, starveCnt_d;
  logic               grant;
  logic               done;
  logic               timeout;
  logic               expire;
  logic               busy;

  logic               memReq_q, memWe_q, memMode_q;
  logic [ADDR_W-1:0]  memAddr_q;
  logic [WORD_W-1:0]  memWdata_q;
  logic               iAck_q, dAck_q;
  logic [INSTR_W-1:0] iRdata_q;
  logic [WORD_W-1:0]  dRdata_q;

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef RVM_ARB_TIMEOUT_EN
  logic err_q;

  arb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (busy),
    .clear_i  (!busy),
    .expire_o (expire)
  );

  // Sticky error: set by any watchdog expiry, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  // Arbitration decision, FSM next state and starvation bookkeeping.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    starveCnt_d = starveCnt_q;
    grant       = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req && !((starveCnt_q == STARVE_LIM) && bus.i_req)) begin
          state_d = BUSY_D;
          gnt_d   = GNT_D;
          grant   = 1'b1;
          if (!bus.i_req) begin
            starveCnt_d = '0;
          end else if (starveCnt_q != STARVE_LIM) begin
            starveCnt_d = starveCnt_q + SW'(1);
          end
        end else if (bus.i_req) begin
          state_d     = BUSY_I;
          gnt_d       = GNT_I;
          grant       = 1'b1;
          starveCnt_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          state_d = RESP;
          done    = 1'b1;
        end else if (expire) begin
          state_d = RESP;
          timeout = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_I;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // Registered memory request, winner's latched fields, ack pulses and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memMode_q  <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      iAck_q     <= 1'b0;
      dAck_q     <= 1'b0;
      iRdata_q   <= '0;
      dRdata_q   <= '0;
    end else begin
      memReq_q <= (state_d == BUSY_I) || (state_d == BUSY_D);
      if (grant) begin
        if (gnt_d == GNT_D) begin
          memWe_q    <= bus.d_we;
          memMode_q  <= bus.d_mode;
          memAddr_q  <= bus.d_addr;
          memWdata_q <= bus.d_wdata;
        end else begin
          memWe_q    <= 1'b0;
          memMode_q  <= 1'b0;
          memAddr_q  <= bus.i_addr;
          memWdata_q <= '0;
        end
      end
      iAck_q <= (done || timeout) && (gnt_q == GNT_I);
      dAck_q <= (done || timeout) && (gnt_q == GNT_D);
      if (gnt_q == GNT_I) begin
        if (done) begin
          iRdata_q <= INSTR_W'(bus.mem_rdata);
        end else if (timeout) begin
          iRdata_q <= '0;
        end
      end else if (!memWe_q) begin
        if (done) begin
          dRdata_q <= bus.mem_rdata;
        end else if (timeout) begin
          dRdata_q <= '0;
        end
      end
    end
  end

  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_mode  = memMode_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.i_ack     = iAck_q;
  assign bus.d_ack     = dAck_q;
  assign bus.i_rdata   = iRdata_q;
  assign bus.d_rdata   = dRdata_q;
  assign bus.i_stall   = bus.i_req && !iAck_q;
  assign bus.d_stall   = bus.d_req && !dAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_MAX = 4, TIMEOUT_CYCLES = 8).
// Build with RVM_ARB_TIMEOUT_EN defined to exercise the watchdog scenario.

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  logic err;
  int   checks;
  int   errors;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got running want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_mode    = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    tick();
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_req: got %0h want 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_we/mode: got %0h/%0h want 0/0", bus.mem_we, bus.mem_mode); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset mem_addr/wdata: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset acks: got %0h/%0h want 0/0", bus.i_ack, bus.d_ack); end
    checks++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset rdata: got %h/%h want 0/0", bus.i_rdata, bus.d_rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset err: got %0h want 0", err); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset state: got %0d want %0d", dut.state_q, IDLE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_only();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL i_only request: got req %0h addr %h we %0h want 1 100 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    checks++; if (bus.i_stall !== 1'b1 || bus.d_stall !== 1'b0) begin errors++; $display("[TB] FAIL i_only stalls: got %0h/%0h want 1/0", bus.i_stall, bus.d_stall); end
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h13579BDF;
    checks++; if (bus.i_ack !== 1'b0 || bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL i_only early_ack: got ack %0h req %0h want 0 1", bus.i_ack, bus.mem_req); end
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h13579BDF) begin errors++; $display("[TB] FAIL i_only ack: got ack %0h rdata %h want 1 13579bdf", bus.i_ack, bus.i_rdata); end
    checks++; if (bus.mem_req !== 1'b0 || bus.i_stall !== 1'b0 || bus.d_stall !== 1'b0) begin errors++; $display("[TB] FAIL i_only resp: got req %0h istall %0h dstall %0h want 0 0 0", bus.mem_req, bus.i_stall, bus.d_stall); end
    bus.i_req = 1'b0;
    tick();
    checks++; if (bus.i_ack !== 1'b0 || bus.i_rdata !== 32'h13579BDF) begin errors++; $display("[TB] FAIL i_only hold: got ack %0h rdata %h want 0 13579bdf", bus.i_ack, bus.i_rdata); end
  endtask

  task automatic test_contention();
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_mode  = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_mode !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL contention d_first: got req %0h we %0h mode %0h addr %h wdata %h want 1 1 1 200 deadbeef", bus.mem_req, bus.mem_we, bus.mem_mode, bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.i_stall !== 1'b1 || bus.d_stall !== 1'b1) begin errors++; $display("[TB] FAIL contention busy_stalls: got %0h/%0h want 1/1", bus.i_stall, bus.d_stall); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hAAAA5555;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0) begin errors++; $display("[TB] FAIL contention d_ack: got d %0h i %0h want 1 0", bus.d_ack, bus.i_ack); end
    checks++; if (bus.d_rdata !== 32'h0 || bus.i_stall !== 1'b1) begin errors++; $display("[TB] FAIL contention write_rdata: got rdata %h istall %0h want 0 1", bus.d_rdata, bus.i_stall); end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    checks++; if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.i_stall !== 1'b1) begin errors++; $display("[TB] FAIL contention gap: got dack %0h req %0h istall %0h want 0 0 1", bus.d_ack, bus.mem_req, bus.i_stall); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL contention i_second: got req %0h addr %h we %0h want 1 300 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL contention i_ack: got ack %0h rdata %h want 1 0badf00d", bus.i_ack, bus.i_rdata); end
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [5:0] expD;
    logic       isD;
    int         n;
    expD       = 6'b101111;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h400;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_mode = 1'b0;
    bus.d_addr = 32'h500;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (bus.mem_req !== 1'b1 && n < 8) begin
        tick();
        n++;
      end
      checks++; if (n >= 8) begin errors++; $display("[TB] FAIL starve wait_req[%0d]: got no mem_req want mem_req within 8 cycles", k); end
      isD = (bus.mem_addr === 32'h500);
      checks++; if (isD !== expD[k]) begin errors++; $display("[TB] FAIL starve order[%0d]: got %s want %s", k, isD ? "D" : "I", expD[k] ? "D" : "I"); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1000 + k;
      tick();
      bus.mem_ready = 1'b0;
      if (expD[k]) begin
        checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h1000 + k) begin errors++; $display("[TB] FAIL starve d_resp[%0d]: got ack %0h rdata %h want 1 %h", k, bus.d_ack, bus.d_rdata, 32'h1000 + k); end
      end else begin
        checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h1000 + k) begin errors++; $display("[TB] FAIL starve i_resp[%0d]: got ack %0h rdata %h want 1 %h", k, bus.i_ack, bus.i_rdata, 32'h1000 + k); end
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write_hold();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h240;
    bus.d_wdata = 32'h12345678;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h12345678 || bus.mem_addr !== 32'h240) begin errors++; $display("[TB] FAIL write_hold request: got we %0h wdata %h addr %h want 1 12345678 240", bus.mem_we, bus.mem_wdata, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEBABE;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h1005) begin errors++; $display("[TB] FAIL write_hold rdata: got ack %0h rdata %h want 1 00001005", bus.d_ack, bus.d_rdata); end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h180;
    tick();
    bus.i_req = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h180) begin errors++; $display("[TB] FAIL req_drop start: got req %0h addr %h want 1 180", bus.mem_req, bus.mem_addr); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h180) begin errors++; $display("[TB] FAIL req_drop held: got req %0h addr %h want 1 180", bus.mem_req, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00000077;
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h00000077) begin errors++; $display("[TB] FAIL req_drop ack: got ack %0h rdata %h want 1 00000077", bus.i_ack, bus.i_rdata); end
    tick();
  endtask

  task automatic test_reset_midflight();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h600;
    tick();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid busy: got req %0h want 1", bus.mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid async_drop: got req %0h ack %0h want 0 0", bus.mem_req, bus.d_ack); end
    bus.d_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (dut.state_q !== IDLE || bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid after: got state %0d ack %0h req %0h want %0d 0 0", dut.state_q, bus.d_ack, bus.mem_req, IDLE); end
    checks++; if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid rdata: got %h/%h want 0/0", bus.d_rdata, bus.i_rdata); end
  endtask

  task automatic test_spurious_ready();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL spurious acks: got i %0h d %0h state %0d want 0 0 %0d", bus.i_ack, bus.d_ack, dut.state_q, IDLE); end
    checks++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL spurious data: got %h/%h req %0h want 0/0 0", bus.i_rdata, bus.d_rdata, bus.mem_req); end
  endtask

`ifdef RVM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h700;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5A5A5A5A;
    tick();
    bus.mem_ready = 1'b0;
    bus.d_req     = 1'b0;
    checks++; if (bus.d_rdata !== 32'h5A5A5A5A || err !== 1'b0) begin errors++; $display("[TB] FAIL timeout pre_read: got rdata %h err %0h want 5a5a5a5a 0", bus.d_rdata, err); end
    tick();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h704;
    n = 0;
    while (bus.d_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("[TB] FAIL timeout latency: got %0d want 9", n); end
    checks++; if (bus.d_rdata !== 32'h0 || err !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL timeout resp: got rdata %h err %0h req %0h want 0 1 0", bus.d_rdata, err, bus.mem_req); end
    bus.d_req = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout sticky: got %0h want 1", err); end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL timeout reset_clear: got %0h want 0", err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`else
  task automatic test_timeout();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h704;
    for (int c = 0; c < 12; c++) begin
      tick();
    end
    checks++; if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout wait: got ack %0h req %0h err %0h want 0 1 0", bus.d_ack, bus.mem_req, err); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h31415926;
    tick();
    bus.mem_ready = 1'b0;
    bus.d_req     = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'h31415926) begin errors++; $display("[TB] FAIL no_timeout ack: got ack %0h rdata %h want 1 31415926", bus.d_ack, bus.d_rdata); end
    tick();
  endtask
`endif

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_i_only();
    test_contention();
    test_starvation();
    test_write_hold();
    test_req_drop();
    test_reset_midflight();
    test_spurious_ready();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
